camera_capture_param: RTL and testbench
=======================================

Name: camera_capture_param

Overview:
Parametrised DVP (OV7670-style) pixel capture block, successor to the fixed 8-bit-to-RGB565 capture path. It assembles 1 or 2 bytes per pixel from p_data under vsync/href framing and applies optional X/Y decimation. It generates linear frame-buffer write addresses and flags malformed lines and frames. It sits between the camera pins and the frame-buffer write port.

Parameters:
DATA_W, 8, camera bus width.
BYTES_PER_PIX, 2, bytes per pixel; legal values are 1 or 2. pixel_data width is DATA_W*BYTES_PER_PIX.
H_ACTIVE, 640, expected pixels per href line.
V_ACTIVE, 480, expected href lines per frame.
DEC_X, 1, horizontal keep-1-of-N; legal values are 1, 2 or 4.
DEC_Y, 1, vertical keep-1-of-N; legal values are 1, 2 or 4.
ADDR_W, 19, write address width.

Ports:
p_clock  in  1  pixel clock; all logic samples on the rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  capture arm; sampled only at frame boundaries.
byte_swap  in  1  0: first byte is MSB; 1: first byte is LSB. Sampled at frame start.
vsync  in  1  frame sync, active high.
href  in  1  line valid, active high.
p_data  in  DATA_W  camera data.
pixel_data  out  DATA_W*BYTES_PER_PIX  assembled pixel.
pixel_valid  out  1  one-cycle strobe per kept pixel.
wraddr  out  ADDR_W  address of the current pixel_data.
line_done  out  1  one-cycle pulse at the href falling edge of a kept line.
frame_done  out  1  one-cycle pulse at end of frame.
line_err  out  1  sticky per frame; at least one line had the wrong length or an odd byte count.
frame_err  out  1  sticky per frame; line count differed from V_ACTIVE.

Behaviour:
- Reset (async assert, sync release): state=IDLE. pixel_data=0, pixel_valid=0, wraddr=0, line_done=0, frame_done=0, line_err=0, frame_err=0. All counters and the byte phase are 0.
- Edge detection uses vsync and href registered one cycle. "Rising edge" means the current sample is 1 and the previous sample was 0.
- State IDLE: on a vsync rising edge with enable=1, go to SYNC.
- State SYNC (vsync high): on vsync low, go to FRAME.
  - On entry to FRAME: wraddr=0, x=0, y=0, line_err=0, frame_err=0; latch byte_swap.
- State FRAME:
  - While href=1, every cycle samples p_data.
  - Byte phase toggles 0/1 when BYTES_PER_PIX=2 and stays 0 when it is 1.
  - The pixel completes on the last byte of the pixel.
  - With byte_swap=0, the first byte is placed in the MSBs.
  - A completed pixel is kept when (x mod DEC_X)==0 and (y mod DEC_Y)==0.
  - A kept pixel drives pixel_data and pixel_valid=1 on the next cycle (latency 1 cycle after the last byte). wraddr holds that pixel's address during the strobe and increments by 1 after it.
  - x increments on every completed pixel, kept or not. x saturates at 2^16-1.
- href falling edge:
  - line_done pulses if the line was kept (y mod DEC_Y==0).
  - line_err sets if x!=H_ACTIVE or the byte phase is not 0.
  - Then x=0, byte phase=0, y=y+1.
- vsync rising edge while in FRAME:
  - frame_done pulses for one cycle.
  - frame_err sets if y!=V_ACTIVE; it becomes visible in the same cycle as frame_done.
  - Next state is SYNC if enable=1, else IDLE. The errors stay held until the next FRAME entry.
- A vsync rise while href=1 is treated as an href fall (line closes) followed by frame end, in that order within the same cycle.
- wraddr wraps modulo 2^ADDR_W. No saturation.
- A href pulse while in IDLE or SYNC is ignored and produces no outputs.
- enable deasserted mid-frame: the current frame completes normally, then the block returns to IDLE.
- An async reset mid-line aborts immediately. No frame_done is generated, and capture waits for a fresh vsync rising edge.

Test Plan:
- BYTES_PER_PIX=2, byte_swap=0, H_ACTIVE=640, V_ACTIVE=2: vsync pulse, then two lines of 1280 bytes starting FF,88,89,... Required: first pixel 0xFF88 at wraddr 0, second pixel 0x898A at wraddr 1. 640 strobes per line, last wraddr=1279, two line_done pulses. The closing vsync rise gives frame_done=1 with line_err=0 and frame_err=0.
- Same stimulus with byte_swap=1 -> first pixel 0x88FF.
- DEC_X=2, DEC_Y=2, 4 lines -> 320 strobes on lines 0 and 2 only. wraddr runs 0..639. line_done pulses twice.
- A line of 1279 bytes (odd count) -> line_err=1 at the href fall and held until the next frame start. A frame with 3 lines against V_ACTIVE=2 -> frame_err=1 together with frame_done.
- rst_n low for 3 cycles mid-line -> all outputs 0 asynchronously. No pixel_valid until after a new vsync pulse. The next frame starts at wraddr 0.
- BYTES_PER_PIX=1: bytes 10,11,12 -> pixel_valid every cycle with pixel_data 0x10, 0x11, 0x12, one cycle after each byte.

Source files
------------

// File: rtl/camera_capture_param.sv
// camera_capture_param
//   DVP (OV7670-style) pixel capture. Assembles one or two bytes per pixel
//   from p_data under vsync/href framing, applies optional X/Y decimation,
//   generates linear frame-buffer write addresses and flags malformed
//   lines and frames.
//
// Ports
//   p_clock      pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       capture arm, sampled at frame boundaries only
//   byte_swap    0: first byte is MSB, 1: first byte is LSB (latched at frame start)
//   vsync, href  frame / line framing, active high
//   p_data       camera data bus
//   pixel_data   assembled pixel, valid with pixel_valid
//   pixel_valid  one-cycle strobe per kept pixel
//   wraddr       frame-buffer address of the current pixel_data
//   line_done    pulse at the href fall of a kept line
//   frame_done   pulse at end of frame
//   line_err     sticky per frame: a line had wrong length or odd byte count
//   frame_err    sticky per frame: line count differed from V_ACTIVE
//
// State  | Meaning
// -------+--------------------------------------------------------------
// IDLE   | disarmed, waiting for a vsync rise with enable=1
// SYNC   | vsync high, waiting for it to drop before the frame body
// FRAME  | frame body: bytes captured while href=1, lines counted
module camera_capture_param #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int DEC_X         = 1,
    parameter int DEC_Y         = 1,
    parameter int ADDR_W        = 19
) (
    input  logic                            p_clock,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            byte_swap,
    input  logic                            vsync,
    input  logic                            href,
    input  logic [DATA_W-1:0]               p_data,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pixel_data,
    output logic                            pixel_valid,
    output logic [ADDR_W-1:0]               wraddr,
    output logic                            line_done,
    output logic                            frame_done,
    output logic                            line_err,
    output logic                            frame_err
);

    localparam int          PIX_W  = DATA_W * BYTES_PER_PIX;
    // Decimation factors are powers of two, so "mod N" is a mask.
    localparam logic [15:0] X_MASK = 16'(DEC_X - 1);
    localparam logic [15:0] Y_MASK = 16'(DEC_Y - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t       state;
    logic         vsync_q;
    logic         href_q;
    logic         phase;
    logic         swap_lat;
    logic [15:0]  x_cnt;
    logic [15:0]  y_cnt;

    logic         vsync_rise;
    logic         href_fall;
    logic         in_frame;
    logic         line_close;
    logic         byte_take;
    logic         pix_done;
    logic         x_keep;
    logic         y_keep;
    logic [15:0]  y_after;
    logic [PIX_W-1:0] pix_asm;

    always_comb begin
        vsync_rise = vsync & ~vsync_q;
        href_fall  = ~href & href_q;
        in_frame   = (state == FRAME);
        // A vsync rise with href still high closes the line first.
        line_close = in_frame && (href_fall || (vsync_rise && href));
        byte_take  = in_frame && href && !vsync_rise;
        pix_done   = byte_take && ((BYTES_PER_PIX == 1) || phase);
        x_keep     = ((x_cnt & X_MASK) == 16'd0);
        y_keep     = ((y_cnt & Y_MASK) == 16'd0);
        y_after    = y_cnt + {15'd0, line_close};
    end

    generate
        if (BYTES_PER_PIX == 2) begin : g_two_byte
            logic [DATA_W-1:0] byte_hold;

            always_ff @(posedge p_clock or negedge rst_n) begin
                if (!rst_n) begin
                    byte_hold <= '0;
                end else if (byte_take && !phase) begin
                    byte_hold <= p_data;
                end
            end

            assign pix_asm = swap_lat ? {p_data, byte_hold} : {byte_hold, p_data};
        end else begin : g_one_byte
            assign pix_asm = p_data;
        end
    endgenerate

    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase       <= 1'b0;
            swap_lat    <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            wraddr      <= '0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            href_q      <= href;
            pixel_valid <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;

            // Address advances the cycle after its strobe, so it stays
            // aligned with pixel_data during pixel_valid.
            if (pixel_valid) begin
                wraddr <= wraddr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (vsync_rise && enable) begin
                        state <= SYNC;
                    end
                end

                SYNC: begin
                    if (!vsync) begin
                        state     <= FRAME;
                        wraddr    <= '0;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        phase     <= 1'b0;
                        line_err  <= 1'b0;
                        frame_err <= 1'b0;
                        swap_lat  <= byte_swap;
                    end
                end

                FRAME: begin
                    if (byte_take) begin
                        phase <= (BYTES_PER_PIX == 2) ? ~phase : 1'b0;
                        if (pix_done) begin
                            if (x_cnt != 16'hFFFF) begin
                                x_cnt <= x_cnt + 16'd1;
                            end
                            if (x_keep && y_keep) begin
                                pixel_data  <= pix_asm;
                                pixel_valid <= 1'b1;
                            end
                        end
                    end

                    if (line_close) begin
                        if (y_keep) begin
                            line_done <= 1'b1;
                        end
                        if ((x_cnt != 16'(H_ACTIVE)) || phase) begin
                            line_err <= 1'b1;
                        end
                        x_cnt <= '0;
                        phase <= 1'b0;
                        y_cnt <= y_after;
                    end

                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        if (y_after != 16'(V_ACTIVE)) begin
                            frame_err <= 1'b1;
                        end
                        state <= enable ? SYNC : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture_param.sv
// Bench for camera_capture_param. Three instances share the camera pins:
//   u_a : 2 bytes/pixel, 640x2, no decimation
//   u_d : 2 bytes/pixel, 640x4, DEC_X=DEC_Y=2
//   u_1 : 1 byte/pixel, 3x1
// Only the instance whose enable is set captures; expected pixels are
// computed by a byte-level model and queued while stimulus is driven.
module tb_camera_capture_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, byte_swap, vsync, href;
    logic [7:0] p_data;
    logic       en_a, en_d, en_1;

    logic [15:0] a_pix;  logic a_val;  logic [18:0] a_addr;
    logic a_ld, a_fd, a_le, a_fe;
    logic [15:0] d_pix;  logic d_val;  logic [18:0] d_addr;
    logic d_ld, d_fd, d_le, d_fe;
    logic [7:0]  o_pix;  logic o_val;  logic [18:0] o_addr;
    logic o_ld, o_fd, o_le, o_fe;

    camera_capture_param #(.DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(640), .V_ACTIVE(2),
                           .DEC_X(1), .DEC_Y(1), .ADDR_W(19)) u_a (
        .p_clock(clk), .rst_n(rst_n), .enable(en_a), .byte_swap(byte_swap),
        .vsync(vsync), .href(href), .p_data(p_data),
        .pixel_data(a_pix), .pixel_valid(a_val), .wraddr(a_addr),
        .line_done(a_ld), .frame_done(a_fd), .line_err(a_le), .frame_err(a_fe));

    camera_capture_param #(.DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(640), .V_ACTIVE(4),
                           .DEC_X(2), .DEC_Y(2), .ADDR_W(19)) u_d (
        .p_clock(clk), .rst_n(rst_n), .enable(en_d), .byte_swap(byte_swap),
        .vsync(vsync), .href(href), .p_data(p_data),
        .pixel_data(d_pix), .pixel_valid(d_val), .wraddr(d_addr),
        .line_done(d_ld), .frame_done(d_fd), .line_err(d_le), .frame_err(d_fe));

    camera_capture_param #(.DATA_W(8), .BYTES_PER_PIX(1), .H_ACTIVE(3), .V_ACTIVE(1),
                           .DEC_X(1), .DEC_Y(1), .ADDR_W(19)) u_1 (
        .p_clock(clk), .rst_n(rst_n), .enable(en_1), .byte_swap(byte_swap),
        .vsync(vsync), .href(href), .p_data(p_data),
        .pixel_data(o_pix), .pixel_valid(o_val), .wraddr(o_addr),
        .line_done(o_ld), .frame_done(o_fd), .line_err(o_le), .frame_err(o_fe));

    typedef struct {
        logic [15:0] pix;
        logic [18:0] addr;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_d[$];
    exp_t q_1[$];

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor-side statistics (written only here, read by the stimulus).
    int a_sv = 0, a_ldc = 0, a_fdc = 0;
    int d_sv = 0, d_ldc = 0, d_fdc = 0;
    int o_sv = 0, o_ldc = 0, o_fdc = 0;
    logic a_fdle, a_fdfe, d_fdle, d_fdfe, o_fdle, o_fdfe;
    logic [15:0] a_first;
    logic [18:0] a_last_addr;

    always @(negedge clk) begin
        exp_t e;
        if (a_val) begin
            a_sv++;
            a_last_addr = a_addr;
            if (a_addr == 19'd0) a_first = a_pix;
            check("a_expected", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_pix", a_pix, e.pix);
                check("a_addr", a_addr, e.addr);
                check("a_latency", cyc, e.cyc);
            end
        end
        if (d_val) begin
            d_sv++;
            check("d_expected", q_d.size() != 0, 1);
            if (q_d.size() != 0) begin
                e = q_d.pop_front();
                check("d_pix", d_pix, e.pix);
                check("d_addr", d_addr, e.addr);
                check("d_latency", cyc, e.cyc);
            end
        end
        if (o_val) begin
            o_sv++;
            check("o_expected", q_1.size() != 0, 1);
            if (q_1.size() != 0) begin
                e = q_1.pop_front();
                check("o_pix", {8'h00, o_pix}, e.pix);
                check("o_addr", o_addr, e.addr);
                check("o_latency", cyc, e.cyc);
            end
        end
        if (a_ld) a_ldc++;
        if (d_ld) d_ldc++;
        if (o_ld) o_ldc++;
        if (a_fd) begin a_fdc++; a_fdle = a_le; a_fdfe = a_fe; end
        if (d_fd) begin d_fdc++; d_fdle = d_le; d_fdfe = d_fe; end
        if (o_fd) begin o_fdc++; o_fdle = o_le; o_fdfe = o_fe; end
    end

    // Byte-level reference model for the selected instance (3 = none).
    int         sel;
    int         m_bpp, m_dx, m_dy, m_x, m_y, m_addr;
    logic       m_phase, m_swap;
    logic [7:0] m_hold;

    task automatic set_sel(input int s);
        sel = s;
        case (s)
            0: begin m_bpp = 2; m_dx = 1; m_dy = 1; end
            1: begin m_bpp = 2; m_dx = 2; m_dy = 2; end
            default: begin m_bpp = 1; m_dx = 1; m_dy = 1; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        logic [15:0] pix;
        logic        done;
        exp_t        e;
        step();
        href   = 1'b1;
        p_data = b;
        if (sel < 3) begin
            done = 1'b0;
            pix  = 16'h0;
            if (m_bpp == 1) begin
                pix = {8'h00, b}; done = 1'b1;
            end else if (!m_phase) begin
                m_hold = b; m_phase = 1'b1;
            end else begin
                pix = m_swap ? {b, m_hold} : {m_hold, b};
                m_phase = 1'b0; done = 1'b1;
            end
            if (done) begin
                if ((m_x % m_dx == 0) && (m_y % m_dy == 0)) begin
                    e.pix = pix; e.addr = 19'(m_addr); e.cyc = cyc + 1;
                    case (sel)
                        0: q_a.push_back(e);
                        1: q_d.push_back(e);
                        default: q_1.push_back(e);
                    endcase
                    m_addr++;
                end
                m_x++;
            end
        end
    endtask

    task automatic send_line(input int nb, input logic [7:0] first, input logic [7:0] second);
        for (int i = 0; i < nb; i++)
            drive_byte((i == 0) ? first : second + 8'(i - 1));
        step();
        href = 1'b0; p_data = 8'h00;
        m_x = 0; m_y++; m_phase = 1'b0;
        repeat (4) step();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        m_x = 0; m_y = 0; m_addr = 0; m_phase = 1'b0; m_swap = byte_swap;
        repeat (3) step();
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        repeat (4) step();
    endtask

    int sv0, ld0, fd0, dsv0;

    initial begin
        rst_n = 1'b0; byte_swap = 1'b0; vsync = 1'b0; href = 1'b0; p_data = 8'h00;
        en_a = 1'b1; en_d = 1'b0; en_1 = 1'b0;
        set_sel(0);
        repeat (3) step();
        check("rst_pix", a_pix, 0);
        check("rst_valid", a_val, 0);
        check("rst_addr", a_addr, 0);
        check("rst_ld", a_ld, 0);
        check("rst_fd", a_fd, 0);
        check("rst_le", a_le, 0);
        check("rst_fe", a_fe, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Two clean lines, MSB first.
        sv0 = a_sv; ld0 = a_ldc; fd0 = a_fdc;
        frame_start();
        send_line(1280, 8'hFF, 8'h88);
        send_line(1280, 8'hFF, 8'h88);
        frame_end();
        check("t1_strobes", a_sv - sv0, 1280);
        check("t1_line_done", a_ldc - ld0, 2);
        check("t1_frame_done", a_fdc - fd0, 1);
        check("t1_line_err", a_fdle, 0);
        check("t1_frame_err", a_fdfe, 0);
        check("t1_first_pix", a_first, 16'hFF88);
        check("t1_last_addr", a_last_addr, 1279);
        check("t1_queue", q_a.size(), 0);

        // Same stimulus, LSB first.
        byte_swap = 1'b1;
        sv0 = a_sv; fd0 = a_fdc;
        frame_start();
        send_line(1280, 8'hFF, 8'h88);
        send_line(1280, 8'hFF, 8'h88);
        frame_end();
        check("t2_strobes", a_sv - sv0, 1280);
        check("t2_first_pix", a_first, 16'h88FF);
        check("t2_frame_done", a_fdc - fd0, 1);
        check("t2_frame_err", a_fdfe, 0);

        // Odd-length line and one line too many.
        byte_swap = 1'b0;
        sv0 = a_sv; ld0 = a_ldc; fd0 = a_fdc;
        frame_start();
        send_line(1280, 8'hFF, 8'h88);
        check("t3_le_clean", a_le, 0);
        send_line(1279, 8'hFF, 8'h88);
        check("t3_le_odd", a_le, 1);
        send_line(1280, 8'hFF, 8'h88);
        check("t3_le_held", a_le, 1);
        frame_end();
        check("t3_strobes", a_sv - sv0, 1919);
        check("t3_line_done", a_ldc - ld0, 3);
        check("t3_frame_done", a_fdc - fd0, 1);
        check("t3_fd_line_err", a_fdle, 1);
        check("t3_fd_frame_err", a_fdfe, 1);
        repeat (3) step();
        check("t3_le_after", a_le, 1);
        check("t3_fe_after", a_fe, 1);

        // Reset in the middle of a line.
        frame_start();
        check("t4_le_cleared", a_le, 0);
        check("t4_fe_cleared", a_fe, 0);
        for (int i = 0; i < 100; i++) drive_byte(8'(i + 3));
        #2;
        rst_n = 1'b0;
        q_a.delete();
        #1;
        check("t4_rst_pix", a_pix, 0);
        check("t4_rst_valid", a_val, 0);
        check("t4_rst_addr", a_addr, 0);
        check("t4_rst_ld", a_ld, 0);
        check("t4_rst_fd", a_fd, 0);
        check("t4_rst_le", a_le, 0);
        check("t4_rst_fe", a_fe, 0);
        sv0 = a_sv; ld0 = a_ldc; fd0 = a_fdc;
        set_sel(3);
        for (int i = 0; i < 3; i++) drive_byte(8'(i));
        rst_n = 1'b1;
        send_line(20, 8'h40, 8'h41);
        check("t4_no_strobe", a_sv - sv0, 0);
        check("t4_no_line_done", a_ldc - ld0, 0);
        check("t4_no_frame_done", a_fdc - fd0, 0);
        set_sel(0);
        frame_start();
        send_line(1280, 8'hFF, 8'h88);
        send_line(1280, 8'hFF, 8'h88);
        en_a = 1'b0;
        frame_end();
        check("t4_strobes", a_sv - sv0, 1280);
        check("t4_frame_done", a_fdc - fd0, 1);
        check("t4_line_err", a_fdle, 0);
        check("t4_frame_err", a_fdfe, 0);
        check("t4_queue", q_a.size(), 0);
        vsync = 1'b0;
        repeat (3) step();

        // Decimation by 2 in both directions; u_a must stay idle.
        set_sel(1);
        en_d = 1'b1;
        sv0 = a_sv; dsv0 = d_sv; ld0 = d_ldc; fd0 = d_fdc;
        frame_start();
        for (int l = 0; l < 4; l++) send_line(1280, 8'hFF, 8'h88);
        en_d = 1'b0;
        frame_end();
        check("t5_strobes", d_sv - dsv0, 640);
        check("t5_line_done", d_ldc - ld0, 2);
        check("t5_frame_done", d_fdc - fd0, 1);
        check("t5_line_err", d_fdle, 0);
        check("t5_frame_err", d_fdfe, 0);
        check("t5_queue", q_d.size(), 0);
        check("t5_a_idle", a_sv - sv0, 0);
        vsync = 1'b0;
        repeat (3) step();

        // One byte per pixel.
        set_sel(2);
        en_1 = 1'b1;
        sv0 = o_sv; ld0 = o_ldc; fd0 = o_fdc;
        frame_start();
        send_line(3, 8'h10, 8'h11);
        en_1 = 1'b0;
        frame_end();
        check("t6_strobes", o_sv - sv0, 3);
        check("t6_line_done", o_ldc - ld0, 1);
        check("t6_frame_done", o_fdc - fd0, 1);
        check("t6_line_err", o_fdle, 0);
        check("t6_frame_err", o_fdfe, 0);
        check("t6_queue", q_1.size(), 0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
